stopwatch_bcd: RTL

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

---
 rtl/stopwatch_pkg.sv | 47 ++++
 rtl/stopwatch_bcd_decade.sv | 35 +++
 rtl/stopwatch_bcd.sv | 137 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and 7-segment codes for the BCD stopwatch.
// Optional lap capture in the top level is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Clamp an arbitrary nibble into the legal BCD range.
  function automatic bcd_t bcd_sat(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_decade.sv
// One BCD decade: load, increment/decrement gated by carry/borrow-in,
// and carry/borrow-out for the next decade up the chain.
module bcd_decade
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  // One chain serves both directions: carry when counting up, borrow when down.
  assign cout = cin & (up ? (digit == 4'd9) : (digit == 4'd0));

  // NOTE: sequential state uses non-blocking assignments so every decade
  // samples its neighbours' pre-edge values and the chain behaves as one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= bcd_sat(load_val);
    end else if (cin) begin
      if (up) digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      else    digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Up/down BCD stopwatch with prescaler, preset load and 7-segment outputs.
// Define STOPWATCH_LAP_EN to build in the lap (display freeze) register.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                up_down,
  input  logic                load_en,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                lap,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [7*DIGITS-1:0] seg_out,
  output logic                running,
  output logic                done,
  output logic                lap_active
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc;
  logic [W-1:0]  count;
  logic [DIGITS:0] carry;
  logic          tick, count_zero, count_one, load_ok, unused_wrap;

  assign tick       = (state_q == ST_RUN) && (presc == PRESC_MAX);
  assign count_zero = (count == '0);
  assign count_one  = (count == W'(1));
  assign load_ok    = load_en && (state_q != ST_RUN);

  // A down-count never borrows past zero; the FSM leaves RUN instead.
  assign carry[0]    = tick && (up_down || !count_zero);
  assign unused_wrap = carry[DIGITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && start)
            state_d = (!up_down && count_zero) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (stop)
            state_d = ST_IDLE;
          else if (!up_down && (count_zero || (tick && count_one)))
            state_d = ST_DONE;
        end
        ST_DONE: begin
          if (load_en) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler only advances while staying in RUN, so any exit discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (state_q == ST_RUN && state_d == ST_RUN && !tick) begin
      presc <= presc + PW'(1);
    end else begin
      presc <= '0;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_decade
    bcd_decade u_decade (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .load     (load_ok),
      .load_val (load_val[4*g +: 4]),
      .up       (up_down),
      .cin      (carry[g]),
      .digit    (count[4*g +: 4]),
      .cout     (carry[g+1])
    );
  end

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_reg;
  logic         lap_q;

  // Capture only happens in RUN; a pending freeze can be released anywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q   <= 1'b0;
      lap_reg <= '0;
    end else if (clear) begin
      lap_q <= 1'b0;
    end else if (lap) begin
      if (lap_q) begin
        lap_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        lap_q   <= 1'b1;
        lap_reg <= count;
      end
    end
  end

  assign lap_active = lap_q;
  assign bcd_out    = lap_q ? lap_reg : count;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign bcd_out    = count;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign seg_out[7*g +: 7] = seg7(bcd_out[4*g +: 4]);
  end

  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule
